// File: rtl/prediction_uart_tx_if.sv
// Handshake between the inference core's result outputs and the UART reporter.
// The core side drives the prediction; the reporter side drives the serial line and status.
interface prediction_uart_tx_if;
    logic [15:0] pred_in;
    logic        pred_done;
    logic        tx;
    logic        busy;
    logic        tx_done;
    logic        overrun;

    modport master (
        output pred_in,
        output pred_done,
        input  tx,
        input  busy,
        input  tx_done,
        input  overrun
    );

    modport slave (
        input  pred_in,
        input  pred_done,
        output tx,
        output busy,
        output tx_done,
        output overrun
    );
endinterface

// File: rtl/prediction_uart_tx.sv
// Captures the inference result on the rising edge of its done level and sends it
// as an ASCII "<digit>\r\n" record over an 8N1 UART line.
module prediction_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_CLASS    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    prediction_uart_tx_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    state_t        state,      state_d;
    logic [BW-1:0] baud_cnt,   baud_cnt_d;
    logic [2:0]    bit_idx,    bit_idx_d;
    logic [1:0]    byte_idx,   byte_idx_d;
    logic [7:0]    cur_byte,   cur_byte_d;
    logic          tx_q,       tx_d;
    logic          tx_done_q,  tx_done_d;
    logic          overrun_q,  overrun_d;
    logic          pred_done_q;

    logic rise;
    logic accept;
    logic bit_end;
    logic unused_pred_hi;

    // Only the low nibble carries the class index.
    assign unused_pred_hi = ^bus.pred_in[15:4];

    assign rise    = bus.pred_done & ~pred_done_q;
    // The tx_done cycle still counts as busy, so a rise landing there is dropped.
    assign accept  = rise && (state == IDLE) && !tx_done_q;
    assign bit_end = (baud_cnt == BAUD_LAST);

    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state;
        baud_cnt_d = '0;
        bit_idx_d  = bit_idx;
        byte_idx_d = byte_idx;
        cur_byte_d = cur_byte;
        tx_done_d  = 1'b0;
        overrun_d  = rise && !accept;

        if (state != IDLE)
            baud_cnt_d = bit_end ? '0 : baud_cnt + 1'b1;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    byte_idx_d = 2'd0;
                    cur_byte_d = (int'(bus.pred_in[3:0]) <= MAX_CLASS)
                               ? 8'h30 + {4'h0, bus.pred_in[3:0]}
                               : 8'h3F;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7)
                        state_d = STOP;
                    else
                        bit_idx_d = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx < 2'd2) begin
                        state_d    = START;
                        byte_idx_d = byte_idx + 2'd1;
                        cur_byte_d = (byte_idx == 2'd0) ? 8'h0D : 8'h0A;
                    end else begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered from the current state, so it lags the FSM by one cycle.
        unique case (state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx];
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            cur_byte    <= '0;
            tx_q        <= 1'b1;
            tx_done_q   <= 1'b0;
            overrun_q   <= 1'b0;
            pred_done_q <= 1'b0;
        end else begin
            state       <= state_d;
            baud_cnt    <= baud_cnt_d;
            bit_idx     <= bit_idx_d;
            byte_idx    <= byte_idx_d;
            cur_byte    <= cur_byte_d;
            tx_q        <= tx_d;
            tx_done_q   <= tx_done_d;
            overrun_q   <= overrun_d;
            pred_done_q <= bus.pred_done;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = (state != IDLE);
    assign bus.tx_done = tx_done_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_prediction_uart_tx.sv
// Scoreboard bench for prediction_uart_tx: expected record bytes are queued when a
// prediction is raised and compared against bytes decoded from the tx line.
module tb_prediction_uart_tx;

    localparam int CPB = 4;

    logic clk;
    logic rst;
    prediction_uart_tx_if pif ();

    prediction_uart_tx #(.CLKS_PER_BIT(CPB), .MAX_CLASS(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    int busy_cnt = 0;
    int done_cnt = 0;
    int ovr_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (pif.busy)    busy_cnt++;
        if (pif.tx_done) done_cnt++;
        if (pif.overrun) ovr_cnt++;
    end

    // UART monitor: start detected half a cycle in, bits sampled mid-bit on falling edges.
    initial begin
        logic [7:0] b;
        logic       stop_bit;
        logic       ok;
        logic [7:0] ch;
        forever begin
            @(negedge clk);
            if (!rst && pif.tx === 1'b0) begin
                b = '0;
                stop_bit = 1'b0;
                ok = 1'b1;
                for (int k = 1; k <= 37; k++) begin
                    @(negedge clk);
                    if (rst) ok = 1'b0;
                    if (k >= 5 && k <= 33 && (k % 4) == 1) b[(k - 5) / 4] = pif.tx;
                    if (k == 37) stop_bit = pif.tx;
                end
                if (ok) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_byte", 32'(exp_q.size()), 32'd1);
                    end else begin
                        ch = exp_q.pop_front();
                        check("rx_byte", {24'h0, b}, {24'h0, ch});
                        check("stop_bit", {31'h0, stop_bit}, 32'd1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_record(input logic [7:0] ch);
        exp_q.push_back(ch);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (pif.tx_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("tx_done_seen", {31'h0, pif.tx_done}, 32'd1);
    endtask

    task automatic run_record(input logic [15:0] pred, input logic [7:0] ch);
        pif.pred_done = 1'b0;
        tick();
        tick();
        pif.pred_in   = pred;
        pif.pred_done = 1'b1;
        push_record(ch);
        wait_done(200);
        repeat (3) tick();
        pif.pred_done = 1'b0;
        tick();
    endtask

    int b0, d0, o0;

    initial begin
        rst           = 1'b1;
        pif.pred_in   = '0;
        pif.pred_done = 1'b0;
        repeat (3) tick();
        check("rst_tx",      {31'h0, pif.tx},      32'd1);
        check("rst_busy",    {31'h0, pif.busy},    32'd0);
        check("rst_tx_done", {31'h0, pif.tx_done}, 32'd0);
        check("rst_overrun", {31'h0, pif.overrun}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic record, done held high well past the record.
        b0 = busy_cnt; d0 = done_cnt; o0 = ovr_cnt;
        pif.pred_in   = 16'h0007;
        pif.pred_done = 1'b1;
        push_record(8'h37);
        tick();
        check("busy_on_capture", {31'h0, pif.busy}, 32'd1);
        check("tx_lag",          {31'h0, pif.tx},   32'd1);
        tick();
        check("tx_start",        {31'h0, pif.tx},   32'd0);
        repeat (198) tick();
        check("busy_cycles", 32'(busy_cnt - b0), 32'd120);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("no_overrun",  32'(ovr_cnt - o0),  32'd0);
        check("q_after_basic", 32'(exp_q.size()), 32'd0);
        pif.pred_done = 1'b0;
        tick();

        run_record(16'h000C, 8'h3F);
        run_record(16'hABC3, 8'h33);
        run_record(16'h0009, 8'h39);

        // Overrun: re-raise mid-record with a different class.
        o0 = ovr_cnt;
        pif.pred_in   = 16'h0002;
        pif.pred_done = 1'b1;
        push_record(8'h32);
        repeat (30) tick();
        pif.pred_done = 1'b0;
        tick();
        pif.pred_in   = 16'h0005;
        pif.pred_done = 1'b1;
        tick();
        tick();
        check("overrun_pulse", 32'(ovr_cnt - o0), 32'd1);
        wait_done(200);
        check("overrun_once", 32'(ovr_cnt - o0), 32'd1);
        run_record(16'h0005, 8'h35);

        // Asynchronous reset in the middle of byte 0's data bits.
        pif.pred_in   = 16'h0004;
        pif.pred_done = 1'b1;
        repeat (15) tick();
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("async_rst_tx",   {31'h0, pif.tx},   32'd1);
        check("async_rst_busy", {31'h0, pif.busy}, 32'd0);
        repeat (30) tick();
        check("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
        pif.pred_in = 16'h0006;
        push_record(8'h36);
        rst = 1'b0;
        wait_done(200);
        check("done_after_reset", 32'(done_cnt - d0), 32'd1);
        repeat (3) tick();
        pif.pred_done = 1'b0;
        tick();

        // Back-to-back: fresh rise on the cycle after tx_done.
        pif.pred_in   = 16'h0001;
        pif.pred_done = 1'b1;
        push_record(8'h31);
        repeat (5) tick();
        pif.pred_done = 1'b0;
        wait_done(200);
        @(posedge clk);
        #1;
        pif.pred_in   = 16'h0008;
        pif.pred_done = 1'b1;
        push_record(8'h38);
        tick();
        tick();
        check("b2b_busy", {31'h0, pif.busy}, 32'd1);
        tick();
        check("b2b_tx_low", {31'h0, pif.tx}, 32'd0);
        wait_done(200);
        repeat (3) tick();
        pif.pred_done = 1'b0;
        tick();

        // Rise landing exactly on the tx_done cycle is dropped.
        pif.pred_in   = 16'h0003;
        pif.pred_done = 1'b1;
        push_record(8'h33);
        repeat (5) tick();
        pif.pred_done = 1'b0;
        wait_done(200);
        o0 = ovr_cnt;
        pif.pred_in   = 16'h0009;
        pif.pred_done = 1'b1;
        tick();
        tick();
        check("edge_overrun", 32'(ovr_cnt - o0), 32'd1);
        repeat (10) tick();
        check("edge_no_capture", {31'h0, pif.busy}, 32'd0);
        pif.pred_done = 1'b0;

        repeat (60) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prediction_uart_tx.md
Name: prediction_uart_tx

Overview:
Downstream consumer of the MNIST inference core. It watches the core's `done` level and captures `final_prediction` on the rising edge of `done`. It then transmits the result over a UART TX line as a 3-byte ASCII record: a digit character, then CR, then LF. This lets a board-level build report the inferred digit to a host terminal without a debugger.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 2.
- MAX_CLASS, 9, highest valid class index; a prediction above this is sent as '?'.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- pred_in  input  16  final_prediction from the inference core; only bits [3:0] are significant.
- pred_done  input  1  `done` level from the inference core; may stay high for many cycles.
- tx  output  1  UART serial out, 8N1, LSB first, idles high.
- busy  output  1  high while a record is being transmitted.
- tx_done  output  1  one-cycle pulse when the last stop bit of the record completes.
- overrun  output  1  one-cycle pulse when a new `pred_done` rising edge arrives while busy.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, tx_done=0, overrun=0.
  - FSM = IDLE; all counters = 0.
  - Edge-detect register = 0, so a `pred_done` already high when reset releases counts as a rising edge on the first active clock.
- Edge detection:
  - `rise = pred_done & ~pred_done_q`, where pred_done_q is registered every cycle.
  - Only `rise` matters; a held-high `pred_done` triggers exactly one record.
- Capture:
  - In IDLE with rise=1, latch the character byte:
    - pred_in[3:0] <= MAX_CLASS: character = 8'h30 + pred_in[3:0].
    - Otherwise: character = 8'h3F ('?').
    - pred_in[15:4] is ignored.
  - Set byte index = 0, enter START, set busy=1 on the same edge.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = current byte[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - byte index < 2: increment it, load the next byte (index 1 = 8'h0D, index 2 = 8'h0A), return to START with no idle gap.
    - byte index == 2: go to IDLE, busy=0, tx_done=1 for that single cycle.
- Timing:
  - tx falls on the first clock edge after the capture edge.
  - A full record lasts exactly 30*CLKS_PER_BIT cycles of busy=1.
  - A new record may be captured on the cycle after tx_done, provided a fresh rise occurs.
- Baud counter:
  - Runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Sized $clog2(CLKS_PER_BIT).
- Overrun:
  - A rise while not in IDLE is dropped; the current record continues unaltered.
  - overrun pulses for 1 cycle.
  - The dropped prediction is not queued.
- Simultaneous events: a rise on the same cycle the FSM returns to IDLE (the tx_done cycle) is treated as busy → dropped, with an overrun pulse.
- Reset mid-record: tx returns high immediately (asynchronously); the partial frame is abandoned; no tx_done.

Test Plan:
- Use CLKS_PER_BIT=4 throughout.
- Basic record: pred_in=16'h0007, pred_done rises and is held high 200 cycles.
  - Expect exactly one record: bytes 0x37, 0x0D, 0x0A, each 8N1.
  - busy high for exactly 120 cycles; one tx_done pulse; no second record.
- Out-of-range class: pred_in=16'h000C.
  - Expect first byte 0x3F, then 0x0D, 0x0A.
- Upper bits ignored: pred_in=16'hABC3.
  - Expect first byte 0x33.
- Overrun: while sending class 2, drop then re-raise pred_done with pred_in=5 mid-record.
  - Expect a 1-cycle overrun pulse and the record still reading "2\r\n".
  - The next rise after tx_done sends "5\r\n".
- Async reset mid-record: assert rst during DATA of byte 0.
  - Expect tx=1, busy=0 immediately, no tx_done.
  - After release, pred_done already high produces a new record.
- Back-to-back: a second rise one cycle after tx_done.
  - Expect tx low on the following cycle, with no idle-bit gap beyond the stop bit.
